// File: rtl/r88_prefetch.sv
// r88_prefetch: instruction prefetch queue for the Rocket88 front end.
// Fetches sequential bytes into a DEPTH-entry circular buffer and presents
// a 3-byte window (opcode + two operands) with the PC of its first byte.
// Decoder consumes 0..3 bytes per cycle; a flush restarts the stream and
// discards responses to requests that were already in flight.
// DEPTH must be a power of two and at least 4.
module r88_prefetch #(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              sysClock,
   input  logic              resetReq,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   input  logic              memGrant,
   input  logic              memValid,
   input  logic [7:0]        memData,
   output logic [7:0]        win0,
   output logic [7:0]        win1,
   output logic [7:0]        win2,
   output logic [2:0]        winValid,
   output logic [ADDR_W-1:0] winPC,
   input  logic [1:0]        consume,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flushAddr,
   output logic              consumeErr
);

   // Pointer width and counter width (counters must hold the value DEPTH).
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

   logic [7:0]        data_q [DEPTH];
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     inflight_q, inflight_d;
   logic [CW-1:0]     discard_q, discard_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] win_pc_q, win_pc_d;
   logic              err_q, err_d;

   logic [CW:0]       occupancy;
   logic              grant;
   logic              wr_en;
   logic              app;
   logic [1:0]        avail;
   logic [1:0]        cons_n;
   logic [7:0]        win_byte [3];

   // Request side: reserve a slot for every outstanding fetch so the queue
   // can never overflow; flush suppresses the request in its own cycle.
   always_comb begin
      occupancy = {1'b0, count_q} + {1'b0, inflight_q};
      memReq    = (occupancy < DEPTH_L) && !resetReq && !flush;
      memAddr   = fetch_pc_q;
      grant     = memReq && memGrant;
   end

   // Window: head bytes, zeroed and marked invalid beyond the current count.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         winValid[k] = (CW'(k) < count_q);
         win_byte[k] = (CW'(k) < count_q) ? data_q[head_q + PW'(k)] : 8'h00;
      end
   end

   assign win0       = win_byte[0];
   assign win1       = win_byte[1];
   assign win2       = win_byte[2];
   assign winPC      = win_pc_q;
   assign consumeErr = err_q;

   // Bytes the decoder may legally take this cycle (window is 3 wide).
   assign avail = (count_q > CW'(3)) ? 2'd3 : count_q[1:0];

   // Next-state: flush overrides consume and append; otherwise consume from
   // the head and append a non-discarded response at the tail.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      discard_d  = discard_q;
      fetch_pc_d = fetch_pc_q;
      win_pc_d   = win_pc_q;
      err_d      = err_q;
      cons_n     = 2'd0;
      app        = 1'b0;
      wr_en      = 1'b0;
      // A grant and a response in the same cycle cancel out.
      inflight_d = inflight_q + CW'(grant) - CW'(memValid);

      if (flush) begin
         head_d     = tail_q;
         count_d    = '0;
         fetch_pc_d = flushAddr;
         win_pc_d   = flushAddr;
         // Everything still outstanding after this cycle belongs to the
         // old stream and must be thrown away when it returns.
         discard_d  = inflight_d;
      end else begin
         if (consume <= avail) begin
            cons_n   = consume;
            head_d   = head_q + PW'(consume);
            win_pc_d = win_pc_q + ADDR_W'(consume);
         end else begin
            err_d = 1'b1;
         end

         if (memValid) begin
            if (discard_q != '0) begin
               discard_d = discard_q - CW'(1);
            end else begin
               wr_en  = 1'b1;
               app    = 1'b1;
               tail_d = tail_q + PW'(1);
            end
         end

         count_d = count_q - CW'(cons_n) + CW'(app);

         if (grant) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
         end
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge sysClock) begin
      if (resetReq) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
         fetch_pc_q <= RESET_PC;
         win_pc_q   <= RESET_PC;
         err_q      <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         fetch_pc_q <= fetch_pc_d;
         win_pc_q   <= win_pc_d;
         err_q      <= err_d;
      end
   end

   // Byte storage; contents are only observed through count, so no reset.
   always_ff @(posedge sysClock) begin
      if (wr_en && !resetReq) begin
         data_q[tail_q] <= memData;
      end
   end

endmodule

// File: tb/tb_r88_prefetch.sv
// Bench for r88_prefetch: a table of directed vectors for reset fill and
// variable consume, hand-written flush / wrap / over-consume / simultaneous
// sequences, and a random phase, all against a queue-based reference model.
module tb_r88_prefetch;

   localparam int DEPTH = 4;
   localparam int AW    = 16;

   logic          sysClock   = 1'b0;
   logic          resetReq   = 1'b1;
   logic          memReq;
   logic [AW-1:0] memAddr;
   logic          memGrant   = 1'b0;
   logic          memValid   = 1'b0;
   logic [7:0]    memData    = 8'h00;
   logic [7:0]    win0, win1, win2;
   logic [2:0]    winValid;
   logic [AW-1:0] winPC;
   logic [1:0]    consume    = 2'd0;
   logic          flush      = 1'b0;
   logic [AW-1:0] flushAddr  = '0;
   logic          consumeErr;

   r88_prefetch #(.DEPTH(DEPTH), .ADDR_W(AW), .RESET_PC(16'h0000)) dut (
      .sysClock  (sysClock),
      .resetReq  (resetReq),
      .memReq    (memReq),
      .memAddr   (memAddr),
      .memGrant  (memGrant),
      .memValid  (memValid),
      .memData   (memData),
      .win0      (win0),
      .win1      (win1),
      .win2      (win2),
      .winValid  (winValid),
      .winPC     (winPC),
      .consume   (consume),
      .flush     (flush),
      .flushAddr (flushAddr),
      .consumeErr(consumeErr)
   );

   always #5 sysClock = ~sysClock;

   int checks = 0;
   int errors = 0;

   // Memory controller: addresses granted and not yet returned, in order.
   logic [AW-1:0] pend [$];

   // Reference model: the queue contents as a plain byte list plus counters.
   logic [7:0]    mq [$];
   int            m_infl;
   int            m_disc;
   logic [AW-1:0] m_fpc;
   logic [AW-1:0] m_wpc;
   logic          m_err;

   // Inputs applied in the current cycle.
   logic          cur_rst, cur_g, cur_f, cur_mv;
   logic [1:0]    cur_c;
   logic [AW-1:0] cur_fa;
   logic [7:0]    cur_md;

   typedef struct packed {
      logic          g;
      logic          r;
      logic [1:0]    c;
      logic          e_req;
      logic [AW-1:0] e_addr;
      logic [2:0]    e_wv;
      logic [AW-1:0] e_pc;
      logic [7:0]    e_w0;
      logic [7:0]    e_w1;
      logic [7:0]    e_w2;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_infl = 0;
      m_disc = 0;
      m_fpc  = '0;
      m_wpc  = '0;
      m_err  = 1'b0;
   endtask

   // Apply this cycle's inputs after the falling edge, then settle.
   task automatic drive(input logic rst, input logic g, input logic r,
                        input logic [1:0] c, input logic f, input logic [AW-1:0] fa);
      @(negedge sysClock);
      cur_rst = rst; cur_g = g; cur_c = c; cur_f = f; cur_fa = fa;
      cur_mv  = !rst && r && (pend.size() > 0);
      cur_md  = cur_mv ? pend[0][7:0] : 8'h00;
      resetReq  = rst;
      memGrant  = g;
      consume   = c;
      flush     = f;
      flushAddr = fa;
      memValid  = cur_mv;
      memData   = cur_md;
      #1;
   endtask

   // Compare DUT against the model, advance memory and model, clock edge.
   task automatic settle();
      logic       exp_req;
      logic [2:0] ewv;
      logic [7:0] ew [3];
      int         nif;
      int         avail;
      exp_req = (mq.size() + m_infl < DEPTH) && !cur_rst && !cur_f;
      for (int k = 0; k < 3; k++) begin
         ewv[k] = (k < mq.size());
         ew[k]  = (k < mq.size()) ? mq[k] : 8'h00;
      end
      chk("m_memReq", memReq, exp_req);
      if (exp_req) chk("m_memAddr", memAddr, m_fpc);
      chk("m_winValid", winValid, ewv);
      chk("m_win0", win0, ew[0]);
      chk("m_win1", win1, ew[1]);
      chk("m_win2", win2, ew[2]);
      chk("m_winPC", winPC, m_wpc);
      chk("m_consumeErr", consumeErr, m_err);

      if (cur_mv) void'(pend.pop_front());
      if (memReq && cur_g) pend.push_back(memAddr);
      if (cur_rst) pend.delete();

      if (cur_rst) begin
         model_reset();
      end else begin
         nif = m_infl + ((exp_req && cur_g) ? 1 : 0) - (cur_mv ? 1 : 0);
         if (cur_f) begin
            mq.delete();
            m_fpc  = cur_fa;
            m_wpc  = cur_fa;
            m_disc = nif;
         end else begin
            avail = (mq.size() < 3) ? mq.size() : 3;
            if (int'(cur_c) <= avail) begin
               repeat (cur_c) void'(mq.pop_front());
               m_wpc = m_wpc + AW'(cur_c);
            end else begin
               m_err = 1'b1;
            end
            if (cur_mv) begin
               if (m_disc > 0) m_disc--;
               else mq.push_back(cur_md);
            end
            if (exp_req && cur_g) m_fpc = m_fpc + 16'd1;
         end
         m_infl = nif;
      end
      @(posedge sysClock);
   endtask

   task automatic cyc(input logic rst, input logic g, input logic r,
                      input logic [1:0] c, input logic f, input logic [AW-1:0] fa);
      drive(rst, g, r, c, f, fa);
      settle();
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0);
      chk("rst_memReq", memReq, 0);
      chk("rst_winValid", winValid, 3'b000);
      chk("rst_winPC", winPC, 16'h0000);
      chk("rst_err", consumeErr, 0);
      chk("rst_win0", win0, 8'h00);
      settle();
   endtask

   initial begin
      int avail;
      logic [1:0] c;

      //            g  r  c     req addr      wv      pc        w0     w1     w2
      tbl[0]  = '{1'b1,1'b1,2'd0, 1'b1,16'h0000,3'b000,16'h0000,8'h00,8'h00,8'h00};
      tbl[1]  = '{1'b1,1'b1,2'd0, 1'b1,16'h0001,3'b000,16'h0000,8'h00,8'h00,8'h00};
      tbl[2]  = '{1'b1,1'b1,2'd0, 1'b1,16'h0002,3'b001,16'h0000,8'h00,8'h00,8'h00};
      tbl[3]  = '{1'b1,1'b1,2'd0, 1'b1,16'h0003,3'b011,16'h0000,8'h00,8'h01,8'h00};
      tbl[4]  = '{1'b1,1'b1,2'd0, 1'b0,16'h0004,3'b111,16'h0000,8'h00,8'h01,8'h02};
      tbl[5]  = '{1'b1,1'b1,2'd0, 1'b0,16'h0004,3'b111,16'h0000,8'h00,8'h01,8'h02};
      tbl[6]  = '{1'b1,1'b1,2'd1, 1'b0,16'h0004,3'b111,16'h0000,8'h00,8'h01,8'h02};
      tbl[7]  = '{1'b1,1'b1,2'd0, 1'b1,16'h0004,3'b111,16'h0001,8'h01,8'h02,8'h03};
      tbl[8]  = '{1'b1,1'b1,2'd3, 1'b0,16'h0005,3'b111,16'h0001,8'h01,8'h02,8'h03};
      tbl[9]  = '{1'b1,1'b1,2'd0, 1'b1,16'h0005,3'b001,16'h0004,8'h04,8'h00,8'h00};
      tbl[10] = '{1'b1,1'b1,2'd0, 1'b1,16'h0006,3'b001,16'h0004,8'h04,8'h00,8'h00};
      tbl[11] = '{1'b1,1'b1,2'd0, 1'b1,16'h0007,3'b011,16'h0004,8'h04,8'h05,8'h00};
      tbl[12] = '{1'b1,1'b1,2'd0, 1'b0,16'h0008,3'b111,16'h0004,8'h04,8'h05,8'h06};

      model_reset();

      // Reset fill and variable consume.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(0, tbl[i].g, tbl[i].r, tbl[i].c, 0, 0);
         chk($sformatf("tbl%0d_memReq", i), memReq, tbl[i].e_req);
         if (tbl[i].e_req) chk($sformatf("tbl%0d_memAddr", i), memAddr, tbl[i].e_addr);
         chk($sformatf("tbl%0d_winValid", i), winValid, tbl[i].e_wv);
         chk($sformatf("tbl%0d_winPC", i), winPC, tbl[i].e_pc);
         chk($sformatf("tbl%0d_win0", i), win0, tbl[i].e_w0);
         chk($sformatf("tbl%0d_win1", i), win1, tbl[i].e_w1);
         chk($sformatf("tbl%0d_win2", i), win2, tbl[i].e_w2);
         settle();
      end

      // Over-consume with a single byte queued.
      do_reset();
      cyc(0, 0, 0, 0, 1, 16'h0050);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 2, 0, 0);
      chk("oc_pre_wv", winValid, 3'b001);
      chk("oc_pre_err", consumeErr, 0);
      settle();
      drive(0, 0, 0, 0, 0, 0);
      chk("oc_err", consumeErr, 1);
      chk("oc_winPC", winPC, 16'h0050);
      chk("oc_win0", win0, 8'h50);
      chk("oc_wv", winValid, 3'b001);
      settle();
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("oc_sticky", consumeErr, 1);
      settle();
      cyc(1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("oc_rst_clear", consumeErr, 0);
      settle();

      // Flush with two requests in flight.
      do_reset();
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 16'h1234);
      chk("fl_req_off", memReq, 0);
      settle();
      drive(0, 1, 1, 0, 0, 0);
      chk("fl_addr0", memAddr, 16'h1234);
      chk("fl_req_on", memReq, 1);
      chk("fl_wv_a", winValid, 3'b000);
      settle();
      drive(0, 1, 1, 0, 0, 0);
      chk("fl_addr1", memAddr, 16'h1235);
      chk("fl_wv_b", winValid, 3'b000);
      settle();
      drive(0, 0, 1, 0, 0, 0);
      chk("fl_wv_c", winValid, 3'b000);
      settle();
      drive(0, 0, 1, 0, 0, 0);
      chk("fl_win0", win0, 8'h34);
      chk("fl_winPC", winPC, 16'h1234);
      chk("fl_wv_d", winValid, 3'b001);
      settle();
      drive(0, 0, 0, 0, 0, 0);
      chk("fl_win1", win1, 8'h35);
      chk("fl_wv_e", winValid, 3'b011);
      settle();

      // Address wrap.
      do_reset();
      cyc(0, 0, 0, 0, 1, 16'hFFFE);
      drive(0, 1, 1, 0, 0, 0);
      chk("wr_addr0", memAddr, 16'hFFFE);
      settle();
      drive(0, 1, 1, 0, 0, 0);
      chk("wr_addr1", memAddr, 16'hFFFF);
      settle();
      drive(0, 1, 1, 0, 0, 0);
      chk("wr_addr2", memAddr, 16'h0000);
      settle();
      cyc(0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 3, 0, 0);
      chk("wr_wv", winValid, 3'b111);
      chk("wr_win0", win0, 8'hFE);
      chk("wr_win2", win2, 8'h00);
      chk("wr_pc_pre", winPC, 16'hFFFE);
      settle();
      drive(0, 0, 0, 0, 0, 0);
      chk("wr_pc_post", winPC, 16'h0001);
      settle();

      // Flush together with consume=2 and a returning byte.
      do_reset();
      cyc(0, 1, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0);
      drive(0, 0, 1, 2, 1, 16'h40AB);
      chk("sim_req", memReq, 0);
      chk("sim_pre_wv", winValid, 3'b011);
      chk("sim_pre_mv", memValid, 1);
      settle();
      drive(0, 1, 1, 0, 0, 0);
      chk("sim_wv", winValid, 3'b000);
      chk("sim_err", consumeErr, 0);
      chk("sim_pc", winPC, 16'h40AB);
      chk("sim_addr", memAddr, 16'h40AB);
      settle();
      cyc(0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("sim_new_wv", winValid, 3'b001);
      chk("sim_new_win0", win0, 8'hAB);
      chk("sim_err_after", consumeErr, 0);
      settle();

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         avail = (mq.size() < 3) ? mq.size() : 3;
         if ($urandom_range(49, 0) == 0) c = 2'($urandom_range(3, 0));
         else c = 2'($urandom_range(avail, 0));
         cyc(($urandom_range(499, 0) == 0),
             ($urandom_range(3, 0) != 0),
             ($urandom_range(2, 0) != 0),
             c,
             ($urandom_range(39, 0) == 0),
             AW'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/r88_prefetch.md
# r88_prefetch

Parametrised instruction prefetch queue for the Rocket88 core. It sits between the memory controller and the instruction decoder. It fetches sequential bytes ahead of execution into a DEPTH-entry FIFO and presents a 3-byte window (opcode plus up to two operands) with its PC. It supports variable-length consumption and branch flush with discard of in-flight responses. This replaces the decoder's one-byte-per-cycle opcode fetch with a decoupled, multi-byte front end.

## Interface

Parameters:
- DEPTH, 4, queue entries; power of two, ≥ 4
- ADDR_W, 16, address width
- RESET_PC, 0, fetch address after reset

Ports:
- sysClock  in  1  system clock; all state updates on posedge
- resetReq  in  1  reset; synchronous, active-high
- memReq  out  1  fetch request to memory controller
- memAddr  out  ADDR_W  fetch address; valid while memReq
- memGrant  in  1  request accepted this cycle
- memValid  in  1  read data returning (in order, ≥1 cycle after grant)
- memData  in  8  read data
- win0, win1, win2  out  8 each  queue head bytes 0..2
- winValid  out  3  thermometer valid mask for win0..win2 (001, 011, 111)
- winPC  out  ADDR_W  address of win0
- consume  in  2  bytes taken by decoder this cycle (0..3)
- flush  in  1  discard stream and restart at flushAddr
- flushAddr  in  ADDR_W  new stream address
- consumeErr  out  1  sticky: consume exceeded valid bytes

## Operation

- Reset state: queue empty, `count` = 0, `inflight` = 0, `discard` = 0, `fetchPC` = `winPC` = RESET_PC, `memReq` = 0, `winValid` = 000, `consumeErr` = 0, `win*` = 00h.
- Request issue:
  - `memReq` = 1 iff `count` + `inflight` < DEPTH, resetReq = 0, and flush = 0.
  - `memAddr` = `fetchPC`.
  - On `memReq` & `memGrant`: `fetchPC` += 1, wrapping modulo 2^ADDR_W, and `inflight` += 1.
  - An ungranted request may change address or drop; memory must not latch it.
- Response:
  - On `memValid`: `inflight` −= 1.
  - If `discard` > 0: `discard` −= 1 and the data is dropped.
  - Otherwise the byte is written at the queue tail.
  - A simultaneous grant and valid leaves `inflight` unchanged.
  - `count` + `inflight` ≤ DEPTH always; the queue never overflows.
- Window:
  - `win`k = entry at head+k when k < `count`, else 00h.
  - `winValid` bit k = (k < `count`).
- Consume:
  - If `consume` ≤ valid bytes: head += `consume`, `count` −= `consume`, `winPC` += `consume` (wrap modulo 2^ADDR_W).
  - If `consume` > valid bytes: `consumeErr` ← 1 (sticky until reset), and head, `count`, and `winPC` are unchanged that cycle.
  - The tail write from a same-cycle `memValid` still occurs.
- Flush (priority over consume and append):
  - `count` ← 0, head = tail.
  - `fetchPC` ← `winPC` ← flushAddr.
  - `discard` ← `inflight` next value, which includes a grant in the flush cycle and excludes a response retired in the flush cycle.
  - A `memValid` in the flush cycle is dropped.
  - `consumeErr` is not evaluated in the flush cycle.
- Reset mid-operation: all state returns to the reset values. Outstanding memory responses after reset are the controller's responsibility; the controller must cancel them on resetReq.
- Pointers are log2(DEPTH) bits and wrap naturally.

## Timing

- Grant at cycle N, memValid at cycle M > N: the byte is visible in the window at M+1.
- Consume at N takes effect at N+1. A byte appended at N is visible at N+1 behind the remaining bytes.
- Flush at N:
  - `memReq` = 0 at N.
  - First request to flushAddr at N+1, with `memAddr` = flushAddr.
  - `winValid` = 000 at N+1.
- With single-cycle memory (valid the cycle after grant), sustained throughput is 1 byte/cycle. After a flush, the first window byte appears at N+3.
- `memReq`, window, and `winPC` are functions of registered state only, except that `memReq` also depends on `flush` and resetReq.

## Test plan

- **Reset fill:** reset, then grant always and memValid one cycle after each grant, with data = low address byte. Required:
  - `memAddr` 0000, 0001, 0002, 0003, then `memReq` = 0 with 4 held.
  - Window shows 00, 01, 02 with `winValid` = 111 and `winPC` = 0000.
- **Variable consume:** with the queue full of 00..03, consume 1 then 3. Required:
  - After consume 1: `winPC` = 0001, `win0` = 01.
  - After consume 3: `winPC` = 0004, and the refill continues at 0004 without gaps.
- **Over-consume:** with `count` = 1, consume 2. Required:
  - `consumeErr` = 1 from the next cycle and stays set.
  - `winPC` and `win0` are unchanged.
  - A later reset clears `consumeErr`.
- **Flush with two in flight:** hold memValid low, flush to 1234h, then return 2 stale bytes followed by new bytes. Required:
  - The stale bytes are dropped.
  - Subsequent `memAddr` = 1234h, 1235h.
  - `win0` = the 1234h data with `winPC` = 1234h.
- **Address wrap:** flush to FFFEh. Required:
  - Fetch addresses FFFEh, FFFFh, 0000h.
  - Consuming 3 yields `winPC` = 0001h.
- **Simultaneous events:** flush in the same cycle as consume = 2 and memValid. Required: flush wins, the returned byte is dropped, and `consumeErr` remains 0.
